// File: rtl/bp_me_loopback_tieoff.sv
// Active tie-off for the CCE memory interface: every accepted mem_cmd is answered by one mem_resp
// carrying the command header and a zero, echoed or pattern payload.
module bp_me_loopback_tieoff #(
    // 0 selects the default processor config (512-bit blocks); any other value selects a 128-bit block config
    parameter int unsigned bp_params_p = 0,
    parameter int unsigned els_p = 2,
    parameter int unsigned data_mode_p = 0,
    parameter logic [63:0] pattern_p = 64'hDEAD_BEEF_0BAD_F00D,
    parameter int unsigned count_width_p = 16,
    localparam int unsigned paddr_width_p = 40,
    localparam int unsigned cce_block_width_p = (bp_params_p == 0) ? 512 : 128,
    // header = {msg_type[3:0], size[2:0], lce_id[7:0], addr[paddr_width_p-1:0]}
    localparam int unsigned mem_header_width_lp = 15 + paddr_width_p,
    localparam int unsigned cce_mem_msg_width_lp = mem_header_width_lp + cce_block_width_p
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_mem_msg_width_lp-1:0] mem_cmd_i,
    input  logic                            mem_cmd_v_i,
    output logic                            mem_cmd_ready_o,
    output logic [cce_mem_msg_width_lp-1:0] mem_resp_o,
    output logic                            mem_resp_v_o,
    input  logic                            mem_resp_yumi_i,
    output logic [count_width_p-1:0]        cmd_count_o,
    output logic                            err_v_o,
    output logic [paddr_width_p-1:0]        err_addr_o,
    input  logic                            err_clear_i
);

    localparam int unsigned ptr_width_lp = $clog2(els_p);
    localparam int unsigned occ_width_lp = $clog2(els_p + 1);
    localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);
    localparam logic [occ_width_lp-1:0] full_occ_lp = occ_width_lp'(els_p);

    logic [mem_header_width_lp-1:0] cmd_header;
    logic [cce_block_width_p-1:0]   cmd_data;
    logic [cce_block_width_p-1:0]   resp_data;
    logic [mem_header_width_lp-1:0] header_mem [els_p];
    logic [ptr_width_lp-1:0]        rd_ptr_r;
    logic [ptr_width_lp-1:0]        wr_ptr_r;
    logic [occ_width_lp-1:0]        occ_r;
    logic                           ready_en_r;
    logic                           full;
    logic                           empty;
    logic                           enq;
    logic                           deq;

    assign cmd_header = mem_cmd_i[cce_mem_msg_width_lp-1 -: mem_header_width_lp];
    assign cmd_data   = mem_cmd_i[cce_block_width_p-1:0];

    assign full            = (occ_r == full_occ_lp);
    assign empty           = (occ_r == '0);
    assign mem_cmd_ready_o = ready_en_r & ~full;
    assign mem_resp_v_o    = ~empty;
    assign enq             = mem_cmd_v_i & mem_cmd_ready_o;
    // An illegal yumi on an empty buffer is ignored so the pointers stay consistent
    assign deq             = mem_resp_yumi_i & ~empty;

    function automatic logic [ptr_width_lp-1:0] ptr_next(input logic [ptr_width_lp-1:0] p);
        return (p == last_ptr_lp) ? '0 : p + ptr_width_lp'(1);
    endfunction

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ready_en_r <= 1'b0;
            rd_ptr_r   <= '0;
            wr_ptr_r   <= '0;
            occ_r      <= '0;
            for (int unsigned i = 0; i < els_p; i++) header_mem[i] <= '0;
        end else begin
            ready_en_r <= 1'b1;
            if (enq) begin
                header_mem[wr_ptr_r] <= cmd_header;
                wr_ptr_r             <= ptr_next(wr_ptr_r);
            end
            if (deq) rd_ptr_r <= ptr_next(rd_ptr_r);
            if (enq && !deq)      occ_r <= occ_r + occ_width_lp'(1);
            else if (deq && !enq) occ_r <= occ_r - occ_width_lp'(1);
        end
    end

    if (data_mode_p == 1) begin : g_echo
        logic [cce_block_width_p-1:0] data_mem [els_p];

        always_ff @(posedge clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                for (int unsigned i = 0; i < els_p; i++) data_mem[i] <= '0;
            end else if (enq) begin
                data_mem[wr_ptr_r] <= cmd_data;
            end
        end

        assign resp_data = data_mem[rd_ptr_r];
    end else begin : g_const
        logic unused_data;
        assign unused_data = ^cmd_data;
        assign resp_data   = (data_mode_p == 2) ? {(cce_block_width_p / 64){pattern_p}} : '0;
    end

    assign mem_resp_o = {header_mem[rd_ptr_r], resp_data};

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cmd_count_o <= '0;
            err_v_o     <= 1'b0;
            err_addr_o  <= '0;
        end else begin
            if (enq && (cmd_count_o != '1)) cmd_count_o <= cmd_count_o + count_width_p'(1);
            // A clear coinciding with an accept re-arms capture on that same command
            if (enq && (!err_v_o || err_clear_i)) begin
                err_v_o    <= 1'b1;
                err_addr_o <= cmd_header[paddr_width_p-1:0];
            end else if (err_clear_i) begin
                err_v_o <= 1'b0;
            end
        end
    end

    a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        mem_resp_yumi_i |-> mem_resp_v_o);

endmodule

// File: tb/tb_bp_me_loopback_tieoff.sv
// Directed bench for bp_me_loopback_tieoff: four instances cover FIFO depth 3, counter
// saturation, echo payload and pattern payload.
module tb_bp_me_loopback_tieoff;

    localparam int HW = 55;
    localparam int DW = 128;
    localparam int MW = HW + DW;
    localparam logic [63:0] PATTERN = 64'hDEAD_BEEF_0BAD_F00D;

    int checks = 0;
    int errors = 0;

    logic clk;
    logic rst_n;

    logic [MW-1:0] a_cmd, a_resp, b_cmd, b_resp, e_cmd, e_resp, p_cmd, p_resp;
    logic a_v, a_ready, a_resp_v, a_yumi, a_err_v, a_clr;
    logic b_v, b_ready, b_resp_v, b_yumi, b_err_v, b_clr;
    logic e_v, e_ready, e_resp_v, e_yumi, e_err_v, e_clr;
    logic p_v, p_ready, p_resp_v, p_yumi, p_err_v, p_clr;
    logic [15:0] a_cnt, e_cnt, p_cnt;
    logic [3:0]  b_cnt;
    logic [39:0] a_err_addr, b_err_addr, e_err_addr, p_err_addr;

    logic [MW-1:0] a_c [4];
    logic [MW-1:0] b_c;
    logic [MW-1:0] e_c [2];
    logic [MW-1:0] p_c;

    bp_me_loopback_tieoff #(.bp_params_p(1), .els_p(3), .data_mode_p(0), .count_width_p(16)) u_a (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(a_cmd), .mem_cmd_v_i(a_v),
        .mem_cmd_ready_o(a_ready), .mem_resp_o(a_resp), .mem_resp_v_o(a_resp_v),
        .mem_resp_yumi_i(a_yumi), .cmd_count_o(a_cnt), .err_v_o(a_err_v),
        .err_addr_o(a_err_addr), .err_clear_i(a_clr));

    bp_me_loopback_tieoff #(.bp_params_p(1), .els_p(2), .data_mode_p(0), .count_width_p(4)) u_b (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(b_cmd), .mem_cmd_v_i(b_v),
        .mem_cmd_ready_o(b_ready), .mem_resp_o(b_resp), .mem_resp_v_o(b_resp_v),
        .mem_resp_yumi_i(b_yumi), .cmd_count_o(b_cnt), .err_v_o(b_err_v),
        .err_addr_o(b_err_addr), .err_clear_i(b_clr));

    bp_me_loopback_tieoff #(.bp_params_p(1), .els_p(2), .data_mode_p(1), .count_width_p(16)) u_e (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(e_cmd), .mem_cmd_v_i(e_v),
        .mem_cmd_ready_o(e_ready), .mem_resp_o(e_resp), .mem_resp_v_o(e_resp_v),
        .mem_resp_yumi_i(e_yumi), .cmd_count_o(e_cnt), .err_v_o(e_err_v),
        .err_addr_o(e_err_addr), .err_clear_i(e_clr));

    bp_me_loopback_tieoff #(.bp_params_p(1), .els_p(2), .data_mode_p(2),
                            .pattern_p(PATTERN), .count_width_p(16)) u_p (
        .clk_i(clk), .reset_n_i(rst_n), .mem_cmd_i(p_cmd), .mem_cmd_v_i(p_v),
        .mem_cmd_ready_o(p_ready), .mem_resp_o(p_resp), .mem_resp_v_o(p_resp_v),
        .mem_resp_yumi_i(p_yumi), .cmd_count_o(p_cnt), .err_v_o(p_err_v),
        .err_addr_o(p_err_addr), .err_clear_i(p_clr));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [MW-1:0] mk(input logic [39:0] addr, input logic [127:0] data,
                                         input logic [3:0] typ);
        return {typ, 3'd6, 8'h05, addr, data};
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic b_step();
        b_yumi = b_resp_v;
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        a_cmd = '0; a_v = 0; a_yumi = 0; a_clr = 0;
        b_cmd = '0; b_v = 0; b_yumi = 0; b_clr = 0;
        e_cmd = '0; e_v = 0; e_yumi = 0; e_clr = 0;
        p_cmd = '0; p_v = 0; p_yumi = 0; p_clr = 0;
        #2;
        chk("rst_a_ready", a_ready, 0);
        chk("rst_a_resp_v", a_resp_v, 0);
        chk("rst_a_cnt", a_cnt, 0);
        chk("rst_a_err_v", a_err_v, 0);
        chk("rst_a_err_addr", a_err_addr, 0);
        chk("rst_p_resp_known", $isunknown(p_resp), 0);
        repeat (2) tick();
        chk("rst_b_ready_held", b_ready, 0);
        chk("rst_a_resp_known", $isunknown(a_resp), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rel_a_ready", a_ready, 1);
        chk("rel_b_ready", b_ready, 1);
        chk("rel_e_ready", e_ready, 1);

        // single command, zero payload, one-cycle latency
        b_c = mk(40'h80_0000_0040, '1, 4'h1);
        b_cmd = b_c; b_v = 1'b1;
        chk("t1_no_bypass", b_resp_v, 0);
        tick();
        b_v = 1'b0;
        chk("t1_resp_v", b_resp_v, 1);
        chk("t1_header", b_resp[MW-1 -: HW], b_c[MW-1 -: HW]);
        chk("t1_data_zero", b_resp[DW-1:0], 0);
        chk("t1_count", b_cnt, 1);
        chk("t1_err_v", b_err_v, 1);
        chk("t1_err_addr", b_err_addr, 40'h80_0000_0040);
        b_yumi = 1'b1;
        tick();
        b_yumi = 1'b0;
        chk("t1_drained", b_resp_v, 0);

        // depth-3 fill with yumi low, then full + simultaneous yumi
        for (int i = 0; i < 4; i++) a_c[i] = mk(40'h1000 + 40'(i * 64), {4{32'(i + 7)}}, 4'(i));
        for (int i = 0; i < 4; i++) begin
            a_cmd = a_c[i]; a_v = 1'b1;
            chk($sformatf("t2_ready%0d", i), a_ready, (i < 3) ? 1 : 0);
            if (i < 3) tick();
        end
        chk("t2_count3", a_cnt, 3);
        a_yumi = 1'b1;
        chk("t3_head0", a_resp[MW-1 -: HW], a_c[0][MW-1 -: HW]);
        tick();
        a_yumi = 1'b0;
        chk("t3_no_accept_cnt", a_cnt, 3);
        chk("t3_ready_next", a_ready, 1);
        chk("t3_head1", a_resp[MW-1 -: HW], a_c[1][MW-1 -: HW]);
        tick();
        a_v = 1'b0;
        chk("t2_count4", a_cnt, 4);
        chk("t2_full_again", a_ready, 0);
        for (int k = 1; k < 4; k++) begin
            chk($sformatf("t2_v%0d", k), a_resp_v, 1);
            chk($sformatf("t2_hdr%0d", k), a_resp[MW-1 -: HW], a_c[k][MW-1 -: HW]);
            chk($sformatf("t2_data%0d", k), a_resp[DW-1:0], 0);
            a_yumi = 1'b1;
            tick();
        end
        a_yumi = 1'b0;
        chk("t2_empty", a_resp_v, 0);

        // echo payload, two entries
        e_c[0] = mk(40'h2000, 128'h0011_2233_4455_6677_0123_4567_89AB_CDEF, 4'h2);
        e_c[1] = mk(40'h2040, 128'hFEDC_BA98_7654_3210_0123_4567_89AB_CDEF, 4'h3);
        e_cmd = e_c[0]; e_v = 1'b1;
        tick();
        e_cmd = e_c[1];
        tick();
        e_v = 1'b0;
        chk("t4_echo_hdr0", e_resp[MW-1 -: HW], e_c[0][MW-1 -: HW]);
        chk("t4_echo_data0", e_resp[DW-1:0], e_c[0][DW-1:0]);
        e_yumi = 1'b1;
        tick();
        chk("t4_echo_data1", e_resp[DW-1:0], e_c[1][DW-1:0]);
        tick();
        e_yumi = 1'b0;
        chk("t4_echo_empty", e_resp_v, 0);
        chk("t4_echo_cnt", e_cnt, 2);
        chk("t4_echo_err_addr", e_err_addr, 40'h2000);

        // pattern payload
        p_c = mk(40'h2800, '1, 4'h4);
        p_cmd = p_c; p_v = 1'b1;
        tick();
        p_v = 1'b0;
        chk("t4_pat_hdr", p_resp[MW-1 -: HW], p_c[MW-1 -: HW]);
        chk("t4_pat_data", p_resp[DW-1:0], {PATTERN, PATTERN});
        chk("t4_pat_err_v", p_err_v, 1);
        p_yumi = 1'b1;
        tick();
        p_yumi = 1'b0;
        chk("t4_pat_cnt", p_cnt, 1);

        // 4-bit counter saturation: 19 more accepts after the first
        for (int i = 0; i < 19; i++) begin
            b_cmd = mk(40'h3000 + 40'(i), '0, 4'h5); b_v = 1'b1;
            b_step();
        end
        b_v = 1'b0;
        b_step();
        b_yumi = 1'b0;
        chk("t5_count_sat", b_cnt, 4'hF);
        chk("t5_err_addr_first", b_err_addr, 40'h80_0000_0040);
        b_clr = 1'b1;
        b_step();
        b_clr = 1'b0;
        chk("t5_clear_v", b_err_v, 0);
        chk("t5_clear_addr_hold", b_err_addr, 40'h80_0000_0040);
        b_cmd = mk(40'h200, '0, 4'h6); b_v = 1'b1;
        b_step();
        chk("t5_recapture", b_err_addr, 40'h200);
        b_cmd = mk(40'h100, '0, 4'h6); b_clr = 1'b1;
        b_step();
        b_clr = 1'b0;
        chk("t5_clr_acc_v", b_err_v, 1);
        chk("t5_clr_acc_addr", b_err_addr, 40'h100);
        b_cmd = mk(40'h300, '0, 4'h6);
        b_step();
        b_v = 1'b0;
        chk("t5_sticky_addr", b_err_addr, 40'h100);
        chk("t5_count_still_sat", b_cnt, 4'hF);
        b_step();
        b_step();
        b_yumi = 1'b0;

        // async reset with two entries queued
        a_cmd = a_c[0]; a_v = 1'b1;
        tick();
        a_cmd = a_c[1];
        tick();
        a_v = 1'b0;
        chk("t6_queued", a_resp_v, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_v", a_resp_v, 0);
        chk("t6_async_ready", a_ready, 0);
        chk("t6_async_cnt", a_cnt, 0);
        chk("t6_async_err_v", a_err_v, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_post_v", a_resp_v, 0);
        chk("t6_post_cnt", a_cnt, 0);
        chk("t6_post_ready", a_ready, 1);
        tick();
        chk("t6_no_stale", a_resp_v, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
